// File: rtl/alu_issue.sv
// Decode/operand-issue stage in front of the cpu32 ALU: 16x32 register file,
// per-register pending scoreboard, registered ALU operation output, writeback port.
module alu_issue #(
  parameter int unsigned NREGS           = 16,
  parameter int unsigned RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_left,
  output logic [31:0] alu_right,
  output logic [3:0]  alu_dst,
  input  logic        wb_en,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  typedef enum logic [3:0] {
    MAJ_REG = 4'h0,
    MAJ_IMM = 4'h1
  } major_e;

  logic [31:0]      regs [NREGS];
  logic [NREGS-1:0] pending, pending_nxt;

  major_e      major;
  logic [3:0]  fa, fb, fc;
  logic [15:0] imm;
  logic        is_reg, is_imm, legal;
  logic        busy_a, busy_b, busy_c, blocked, room, xfer, issue;
  logic [31:0] opnd_b, opnd_c;

  if (RESET_PC_UNUSED != 0) begin : g_reserved
  end

  always_comb begin
    major  = major_e'(in_instr[31:28]);
    fa     = in_instr[27:24];
    fb     = in_instr[23:20];
    fc     = in_instr[19:16];
    imm    = in_instr[15:0];
    is_reg = (major == MAJ_REG);
    is_imm = (major == MAJ_IMM);
    legal  = is_reg || is_imm;

    // A register being written back this cycle no longer blocks its readers.
    busy_a = (fa != '0) && pending[fa] && !(wb_en && (wb_sel == fa));
    busy_b = (fb != '0) && pending[fb] && !(wb_en && (wb_sel == fb));
    busy_c = (fc != '0) && pending[fc] && !(wb_en && (wb_sel == fc));

    blocked  = legal && (busy_a || busy_b || (is_reg && busy_c));
    room     = !out_valid || out_ready;
    in_ready = !blocked && room;
    xfer     = in_valid && in_ready;
    issue    = xfer && legal;

    opnd_b = (fb == '0) ? '0 : ((wb_en && (wb_sel == fb)) ? wb_data : regs[fb]);
    opnd_c = (fc == '0) ? '0 : ((wb_en && (wb_sel == fc)) ? wb_data : regs[fc]);

    // Clear on writeback first so a same-cycle issue to that register wins.
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_sel] = 1'b0;
    if (issue && (fa != '0)) pending_nxt[fa] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_sel != '0)) begin
      regs[wb_sel] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      alu_opcode <= '0;
      alu_left   <= '0;
      alu_right  <= '0;
      alu_dst    <= '0;
    end else begin
      pending <= pending_nxt;
      illegal <= xfer && !legal;
      if (issue) begin
        out_valid  <= 1'b1;
        alu_opcode <= is_reg ? imm[3:0] : fc;
        alu_left   <= opnd_b;
        alu_right  <= is_reg ? opnd_c : {16'h0000, imm};
        alu_dst    <= fa;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model built from arrays.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, wb_en, illegal;
  logic [31:0] in_instr, alu_left, alu_right, wb_data;
  logic [3:0]  alu_opcode, alu_dst, wb_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [31:0] mreg  [16];
  logic        mpend [16];
  logic        mov, mill;
  logic [3:0]  mop, md;
  logic [31:0] ml, mr;
  logic        exp_ready, obs_ready;

  always #5 clk = ~clk;

  alu_issue #(.NREGS(16), .RESET_PC_UNUSED(0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_opcode(alu_opcode), .alu_left(alu_left), .alu_right(alu_right), .alu_dst(alu_dst),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .illegal(illegal)
  );

  function automatic logic m_busy(input logic [3:0] s);
    return (s != 4'd0) && mpend[s] && !(wb_en && wb_sel == s);
  endfunction

  function automatic logic [31:0] m_val(input logic [3:0] s);
    if (s == 4'd0) return 32'd0;
    if (wb_en && wb_sel == s) return wb_data;
    return mreg[s];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mreg[i]  = 32'd0;
      mpend[i] = 1'b0;
    end
    mov = 1'b0; mill = 1'b0; mop = 4'd0; md = 4'd0; ml = 32'd0; mr = 32'd0;
  endtask

  // One clock cycle: drive inputs at posedge+1, sample in_ready at the falling
  // edge, advance the model, return at the next posedge+1.
  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                      input logic we, input logic [3:0] ws, input logic [31:0] wd);
    logic [3:0] maj, a, b, c;
    logic legal, take;
    in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_sel = ws; wb_data = wd;
    maj = ins[31:28]; a = ins[27:24]; b = ins[23:20]; c = ins[19:16];
    legal = (maj == 4'h0) || (maj == 4'h1);
    exp_ready = !(legal && (m_busy(a) || m_busy(b) || (maj == 4'h0 && m_busy(c))))
                && (!mov || ordy);
    #4 obs_ready = in_ready;
    take = iv && exp_ready;
    mill = take && !legal;
    if (take && legal) begin
      mov = 1'b1;
      md  = a;
      ml  = m_val(b);
      mr  = (maj == 4'h0) ? m_val(c) : {16'h0000, ins[15:0]};
      mop = (maj == 4'h0) ? ins[3:0] : c;
    end else if (mov && ordy) begin
      mov = 1'b0;
    end
    if (we && ws != 4'd0) mreg[ws] = wd;
    if (we) mpend[ws] = 1'b0;
    if (take && legal && a != 4'd0) mpend[a] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, ordy, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic wb(input logic [3:0] s, input logic [31:0] d);
    step(1'b0, 32'd0, 1'b1, 1'b1, s, d);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    wb_en = 1'b0; wb_sel = 4'd0; wb_data = 32'd0;
    model_clear();
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, illegal, alu_opcode, alu_dst, alu_left, alu_right, in_ready} !== {1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1})
      begin n_fail++; $display("FAIL reset_state got v=%b i=%b op=%h d=%h l=%h r=%h rdy=%b want all zero, rdy=1",
        out_valid, illegal, alu_opcode, alu_dst, alu_left, alu_right, in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_reg_form();
    wb(4'd2, 32'd5);
    wb(4'd3, 32'd7);
    step(1'b1, 32'h0023_0002, 1'b1, 1'b0, 4'd0, 32'd0);
    n_checks++;
    if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reg_ready got %b want 1", obs_ready); end
    n_checks++;
    if ({out_valid, alu_opcode, alu_left, alu_right, alu_dst} !== {1'b1, 4'h2, 32'd5, 32'd7, 4'h0})
      begin n_fail++; $display("FAIL reg_issue got v=%b op=%h l=%h r=%h d=%h want 1 2 5 7 0",
        out_valid, alu_opcode, alu_left, alu_right, alu_dst); end
  endtask

  task automatic test_imm_hazard_bypass();
    step(1'b1, 32'h1420_1234, 1'b1, 1'b0, 4'd0, 32'd0);
    n_checks++;
    if ({out_valid, alu_opcode, alu_left, alu_right, alu_dst} !== {1'b1, 4'h0, 32'd5, 32'h0000_1234, 4'h4})
      begin n_fail++; $display("FAIL imm_issue got v=%b op=%h l=%h r=%h d=%h want 1 0 5 1234 4",
        out_valid, alu_opcode, alu_left, alu_right, alu_dst); end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 32'h0543_0000, 1'b1, 1'b0, 4'd0, 32'd0);
      n_checks++;
      if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_block cyc=%0d got rdy=%b want 0", k, obs_ready); end
    end
    step(1'b1, 32'h0543_0000, 1'b1, 1'b1, 4'd4, 32'h99);
    n_checks++;
    if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got %b want 1", obs_ready); end
    n_checks++;
    if ({out_valid, alu_left, alu_right, alu_dst} !== {1'b1, 32'h99, 32'd7, 4'h5})
      begin n_fail++; $display("FAIL bypass_value got v=%b l=%h r=%h d=%h want 1 99 7 5",
        out_valid, alu_left, alu_right, alu_dst); end
    wb(4'd5, 32'd1);
  endtask

  task automatic test_stall_hold();
    step(1'b1, 32'h0650_0003, 1'b0, 1'b0, 4'd0, 32'd0);
    n_checks++;
    if ({obs_ready, out_valid, alu_opcode, alu_left, alu_dst} !== {1'b1, 1'b1, 4'h3, 32'd1, 4'h6})
      begin n_fail++; $display("FAIL stall_issue got rdy=%b v=%b op=%h l=%h d=%h want 1 1 3 1 6",
        obs_ready, out_valid, alu_opcode, alu_left, alu_dst); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h0750_0000, 1'b0, (k == 1), 4'd5, 32'd2);
      n_checks++;
      if ({obs_ready, out_valid, alu_opcode, alu_left, alu_right, alu_dst} !== {1'b0, 1'b1, 4'h3, 32'd1, 32'd0, 4'h6})
        begin n_fail++; $display("FAIL stall_hold cyc=%0d got rdy=%b v=%b op=%h l=%h r=%h d=%h want 0 1 3 1 0 6",
          k, obs_ready, out_valid, alu_opcode, alu_left, alu_right, alu_dst); end
    end
    step(1'b1, 32'h0750_0000, 1'b1, 1'b0, 4'd0, 32'd0);
    n_checks++;
    if ({obs_ready, out_valid, alu_left, alu_dst} !== {1'b1, 1'b1, 32'd2, 4'h7})
      begin n_fail++; $display("FAIL stall_resume got rdy=%b v=%b l=%h d=%h want 1 1 2 7",
        obs_ready, out_valid, alu_left, alu_dst); end
  endtask

  task automatic test_illegal();
    step(1'b1, 32'hF300_0000, 1'b1, 1'b0, 4'd0, 32'd0);
    n_checks++;
    if ({obs_ready, out_valid, illegal} !== 3'b101)
      begin n_fail++; $display("FAIL illegal_pulse got rdy=%b v=%b ill=%b want 1 0 1", obs_ready, out_valid, illegal); end
    idle(1'b1);
    n_checks++;
    if ({out_valid, illegal} !== 2'b00)
      begin n_fail++; $display("FAIL illegal_clear got v=%b ill=%b want 0 0", out_valid, illegal); end
    step(1'b1, 32'h0030_0000, 1'b1, 1'b0, 4'd0, 32'd0);
    n_checks++;
    if ({obs_ready, out_valid, alu_left, alu_dst} !== {1'b1, 1'b1, 32'd7, 4'h0})
      begin n_fail++; $display("FAIL illegal_no_pend got rdy=%b v=%b l=%h d=%h want 1 1 7 0",
        obs_ready, out_valid, alu_left, alu_dst); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [4];
    logic [3:0]  dsts [4];
    prog[0] = 32'h0823_0001; dsts[0] = 4'h8;
    prog[1] = 32'h1920_0010; dsts[1] = 4'h9;
    prog[2] = 32'h0A32_0004; dsts[2] = 4'hA;
    prog[3] = 32'h1B30_00FF; dsts[3] = 4'hB;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, prog[k], 1'b1, 1'b0, 4'd0, 32'd0);
      n_checks++;
      if ({obs_ready, out_valid, alu_dst} !== {1'b1, 1'b1, dsts[k]})
        begin n_fail++; $display("FAIL b2b cyc=%0d got rdy=%b v=%b d=%h want 1 1 %h",
          k, obs_ready, out_valid, alu_dst, dsts[k]); end
    end
    idle(1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    wb(4'd6, 32'h55);
    step(1'b1, 32'h1600_0000, 1'b0, 1'b0, 4'd0, 32'd0);
    idle(1'b0);
    n_checks++;
    if ({out_valid, alu_dst} !== {1'b1, 4'h6})
      begin n_fail++; $display("FAIL pre_reset_stall got v=%b d=%h want 1 6", out_valid, alu_dst); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, alu_opcode, alu_left, alu_right, alu_dst} !== {1'b0, 4'd0, 32'd0, 32'd0, 4'd0})
      begin n_fail++; $display("FAIL async_reset got v=%b op=%h l=%h r=%h d=%h want all zero",
        out_valid, alu_opcode, alu_left, alu_right, alu_dst); end
    model_clear();
    @(posedge clk); #1 reset = 1'b0;
    step(1'b1, 32'h0060_0000, 1'b1, 1'b0, 4'd0, 32'd0);
    n_checks++;
    if ({obs_ready, out_valid, alu_left} !== {1'b1, 1'b1, 32'd0})
      begin n_fail++; $display("FAIL post_reset_r6 got rdy=%b v=%b l=%h want 1 1 0", obs_ready, out_valid, alu_left); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ins = $urandom;
      r = $urandom_range(0, 9);
      ins[31:28] = (r < 4) ? 4'h0 : (r < 8) ? 4'h1 : 4'($urandom_range(2, 15));
      step(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), $urandom);
      n_checks++;
      if (obs_ready !== exp_ready)
        begin n_fail++; $display("FAIL rand_ready cyc=%0d instr=%h got %b want %b", cyc, in_instr, obs_ready, exp_ready); end
      n_checks++;
      if ({out_valid, illegal, alu_opcode, alu_dst, alu_left, alu_right} !== {mov, mill, mop, md, ml, mr})
        begin n_fail++; $display("FAIL rand_out cyc=%0d got v=%b i=%b op=%h d=%h l=%h r=%h want v=%b i=%b op=%h d=%h l=%h r=%h",
          cyc, out_valid, illegal, alu_opcode, alu_dst, alu_left, alu_right, mov, mill, mop, md, ml, mr); end
    end
  endtask

  initial begin
    test_reset();
    test_reg_form();
    test_imm_hazard_bypass();
    test_stall_hold();
    test_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode and operand-issue stage that sits in front of the cpu32 ALU and drives its opcode/left/right inputs.
- Accepts 32-bit instruction words over a valid/ready handshake and holds a 16x32 register file.
- Tracks pending destinations with a scoreboard.
- Issues a registered ALU operation with its destination tag.
- Accepts the ALU result back through a writeback port.

Parameters:
- NREGS, 16, number of architectural registers; fixed at 16 because select fields are 4 bits.
- RESET_PC_UNUSED, 0, reserved, must stay 0 (no effect).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction word valid.
- in_instr  input  32  instruction word.
- in_ready  output  1  stage accepts in_instr this cycle.
- out_valid  output  1  ALU operation valid.
- out_ready  input  1  downstream consumes the operation.
- alu_opcode  output  4  ALU function select.
- alu_left  output  32  left operand.
- alu_right  output  32  right operand.
- alu_dst  output  4  destination register for the result.
- wb_en  input  1  writeback strobe.
- wb_sel  input  4  writeback register.
- wb_data  input  32  writeback value (ALU out).
- illegal  output  1  one-cycle pulse when an undecodable instruction is consumed.

Behaviour:
- Instruction fields:
  - [31:28] major opcode
  - [27:24] A (destination)
  - [23:20] B
  - [19:16] C
  - [15:0] imm16
- major 0000 (register form):
  - alu_opcode = imm16[3:0]
  - left = R[B], right = R[C], dst = A
- major 0001 (immediate form):
  - alu_opcode = C
  - left = R[B], right = {16'h0, imm16}, dst = A
  - Sign extension and high placement are performed by the ALU itself (ops 1110 and 1111).
- All other major values are illegal.
- Register file:
  - R0 always reads 0 and is never pending.
  - wb_en with wb_sel=0 is ignored.
  - Writes take effect at the clock edge.
- Read bypass: if wb_en and wb_sel equals the source register (nonzero) in the same cycle, the operand takes wb_data, not the stale value.
- Scoreboard: one pending bit per register.
  - Set for A when an instruction issues with A != 0.
  - Cleared on wb_en for wb_sel.
  - If issue and writeback target the same register in the same cycle, set wins.
- Hazard: a source is blocked if its pending bit is set and it is not being written back this cycle.
  - Register form checks B and C.
  - Immediate form checks B only.
  - Destination A is also blocked if pending, so writebacks stay in order.
- in_ready = !blocked && (!out_valid || out_ready).
  - blocked is evaluated only for legal decodes.
  - Illegal instructions are always accepted when (!out_valid || out_ready).
- Transfer occurs when in_valid && in_ready.
  - Legal: output registers load at the edge, out_valid=1 next cycle. Latency is 1 cycle from accept to out_valid.
  - Illegal: out_valid unchanged by this instruction, illegal=1 for exactly the next cycle, scoreboard untouched.
- Output hold: while out_valid && !out_ready, alu_opcode/left/right/dst are stable.
  - Operands are captured at issue. Writebacks during the stall do not alter them.
- out_valid clears after (out_valid && out_ready) unless a new legal instruction transfers in the same cycle.
  - Back-to-back issue gives full throughput.
- wb_en for a non-pending register still writes the value; the scoreboard is unaffected.
- Reset (async, any cycle including mid-stall):
  - out_valid=0, illegal=0
  - alu_opcode=0, alu_left=0, alu_right=0, alu_dst=0
  - all pending bits=0, all registers=0
  - in_ready recomputes combinationally to 1.
- in_ready depends combinationally on in_instr, in_valid-independent, on out_ready, and on wb_en/wb_sel. No combinational path from in_valid to in_ready.

Test Plan:
- Reset, then write R2=5 and R3=7 via wb, then issue 0x0023_0002 (reg form, A=0? no: A=0, B=2, C=3, op=2) with out_ready=1 -> next cycle out_valid=1, opcode=2, left=5, right=7, dst=0; no pending bit set.
- Issue imm form 0x1420_1234 (A=4, B=2, op=0) -> left=5, right=0x00001234, dst=4; pending[4]=1. Then issue 0x0543_0000 (B=4) -> in_ready=0 until wb_en sel=4 data=0x99; in the wb cycle in_ready=1 and left=0x99 (bypass).
- Hold out_ready=0 for 3 cycles after issue with left=R5=1, and write R5=2 mid-stall -> outputs unchanged (left=1); accept resumes on out_ready=1.
- Issue 0xF000_0000 -> consumed with in_ready=1, illegal pulses for 1 cycle, out_valid stays 0, scoreboard unchanged.
- Stream 4 independent legal instructions with out_ready=1 -> 4 consecutive out_valid cycles, no bubbles.
- Assert reset during a stall with pending[6]=1 -> out_valid=0 immediately, R6 reads 0 and is not pending after reset release.
